poly_basemul: RTL and testbench
===============================

Name: poly_basemul

Overview:
- Pointwise multiply stage that consumes two NTT-domain polynomials, typically the forward NTT output and a matrix or secret polynomial, in the Kyber768 datapath.
- Computes the 128 degree-1 products mod (X^2 − ζ) with Montgomery arithmetic and produces one 256-coefficient NTT-domain result.
- The result is consumed by the accumulator or inverse NTT.
- Uses a start/busy/done handshake and processes LANES coefficient pairs per iteration.

Parameters:
- LANES, 4: basemul units operating in parallel. Must divide 128; G = 128/LANES iterations.
- Q, 3329: Kyber modulus.
- QINV, -3327: q^-1 mod 2^16, signed, used by Montgomery reduce.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- start, input, 1: request; sampled only in IDLE.
- in_a, input, signed 16 ×256: polynomial A, NTT domain.
- in_b, input, signed 16 ×256: polynomial B, NTT domain.
- out, output, signed 16 ×256: registered result R.
- busy, output, 1: high from the start-accept edge until done.
- done, output, 1: single-cycle pulse when out is updated.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset: state=IDLE, busy=0, done=0, out all 0, internal buffers 0, grp=0.
  - Applies mid-operation too: the operation is aborted, no done pulse, out cleared.
- fqmul(x,y): p = x*y (32-bit signed); t = int16(p*QINV); r = (p − t*Q) >>> 16 (arithmetic); r is 16-bit signed, |r| < Q.
- Zeta table: 64 signed 16-bit Montgomery-form constants, equal to the Kyber zetas[64..127]. Entry 0 = 2226.
- Pair i (0..127) covers coefficients 2i and 2i+1.
  - z_i = +ZT[i>>1] for even i, −ZT[i>>1] for odd i.
  - r[2i] = fqmul(fqmul(a[2i+1], b[2i+1]), z_i) + fqmul(a[2i], b[2i]).
  - r[2i+1] = fqmul(a[2i], b[2i+1]) + fqmul(a[2i+1], b[2i]).
  - Additions are 16-bit two's-complement wrap. No final reduction.
- FSM states: IDLE, MUL1, MUL2, WRITE, FINISH.
  - IDLE: busy=0. If start=1, capture in_a/in_b into buffers, set grp=0, busy<=1, go to MUL1. in_a/in_b are don't-care afterwards.
  - MUL1: for lanes l=0..LANES−1 with pair i = grp*LANES+l, register the four first-level fqmul products. Go to MUL2.
  - MUL2: register fqmul(p11, z_i) per lane. Go to WRITE.
  - WRITE: write r[2i], r[2i+1] into the result buffer. If grp == G−1 go to FINISH, else grp++ and go to MUL1.
  - FINISH: copy the result buffer to out, done<=1, busy<=0, go to IDLE.
- done is high for exactly one cycle. out holds its value until the next FINISH or reset.
- Latency: done is visible after the (1+3G)-th rising edge following the edge that accepted start. With LANES=4 this is 97 edges.
- start while busy=1 is ignored and not queued. start held high is re-accepted on the IDLE cycle right after done.
- The only multi-cycle paths are the register stages above. No combinational path from in_a/in_b to out.

Test Plan:
- All-zero inputs, start pulse -> done after exactly 97 edges, busy high for 97 cycles, all out = 0.
- a[0]=2285, b[0]=5, all other coefficients 0 -> out[0]=5, all other out = 0.
- a[1]=b[1]=2285, all others 0 -> out[0]=−1103 (fqmul(2285,2285)=−1044, then × +2226); out[1]=0.
- a[3]=b[3]=2285, all others 0 -> pair 1 uses −2226, so out[2]=+1103; all others 0.
- start re-pulsed at cycles 10 and 50 while busy -> ignored; exactly one done at 97; a second start after done gives a second done 97 edges later with new data.
- reset asserted at cycle 40 of an operation -> next cycle busy=0, done=0, out all 0; no done pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/poly_basemul_if.sv
// Bundle for the pointwise-multiply stage: start request, the two NTT-domain
// operand polynomials, the registered result, busy/done status and the
// current FSM state for observation.
//
// Handshake: the stage samples start only while idle; the cycle after the
// sampling edge busy is high and in_a/in_b are no longer read. busy stays
// high until the edge that raises done; done is a one-cycle pulse that
// coincides with out taking its new value. A start seen while busy is
// dropped, not queued.
interface poly_basemul_if;
    logic               start;
    logic signed [15:0] in_a [256];
    logic signed [15:0] in_b [256];
    logic signed [15:0] out  [256];
    logic               busy;
    logic               done;
    logic [2:0]         state;

    modport master (
        output start, in_a, in_b,
        input  out, busy, done, state
    );

    modport slave (
        input  start, in_a, in_b,
        output out, busy, done, state
    );
endinterface

// File: rtl/poly_basemul.sv
// Kyber pointwise multiply: 128 degree-1 products mod (X^2 - zeta) with
// Montgomery reduction, LANES pairs per iteration, three register stages
// per iteration (first-level products, zeta product, result write-back).
module poly_basemul #(
    parameter int LANES = 4,
    parameter int Q     = 3329,
    parameter int QINV  = -3327
) (
    input logic          clk,
    input logic          reset,
    poly_basemul_if.slave bus
);

    localparam int          G      = 128 / LANES;
    localparam int          LB     = $clog2(LANES);
    localparam logic [31:0] Q32    = 32'(Q);
    localparam logic [15:0] QINV16 = 16'(QINV);

    // Montgomery-form twiddles for the 64 quadratic factors (zetas[64..127]).
    localparam logic signed [15:0] ZT [64] = '{
        2226,  430,  555,  843, 2078,  871, 1550,  105,
         422,  587,  177, 3094, 3038, 2869, 1574, 1653,
        3083,  778, 1159, 3182, 2552, 1483, 2727, 1119,
        1739,  644, 2457,  349,  418,  329, 3173, 3254,
         817, 1097,  603,  610, 1322, 2044, 1864,  384,
        2114, 3193, 1218, 1994, 2455,  220, 2142, 1670,
        2144, 1799, 2051,  794, 1819, 2475, 2459,  478,
        3221, 3021,  996,  991,  958, 1869, 1522, 1628
    };

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL1   = 3'd1,
        S_MUL2   = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    // Montgomery product: x*y*2^-16 mod q, result in (-q, q).
    function automatic logic signed [15:0] fqmul(
        input logic signed [15:0] x,
        input logic signed [15:0] y
    );
        logic [31:0] p;
        logic [15:0] t;
        logic [31:0] r;
        p = {{16{x[15]}}, x} * {{16{y[15]}}, y};
        t = p[15:0] * QINV16;
        r = p - ({{16{t[15]}}, t} * Q32);
        return r[31:16];
    endfunction

    state_t             state_q;
    logic [6:0]         grp_q;
    logic               busy_q;
    logic               done_q;
    logic signed [15:0] a_q   [256];
    logic signed [15:0] b_q   [256];
    logic signed [15:0] res_q [256];
    logic signed [15:0] out_q [256];
    logic signed [15:0] m00_q [LANES];
    logic signed [15:0] m11_q [LANES];
    logic signed [15:0] m01_q [LANES];
    logic signed [15:0] m10_q [LANES];
    logic signed [15:0] m11z_q[LANES];

    logic [6:0]         pair_w [LANES];
    logic signed [15:0] zeta_w [LANES];

    // Pair index handled by each lane this iteration and its signed twiddle.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            pair_w[l] = (grp_q << LB) + 7'(l);
            zeta_w[l] = pair_w[l][0] ? -ZT[pair_w[l][6:1]] : ZT[pair_w[l][6:1]];
        end
    end

    // Control FSM together with the operand, pipeline and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 256; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
                out_q[k] <= '0;
            end
            for (int l = 0; l < LANES; l++) begin
                m00_q[l]  <= '0;
                m11_q[l]  <= '0;
                m01_q[l]  <= '0;
                m10_q[l]  <= '0;
                m11z_q[l] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        for (int k = 0; k < 256; k++) begin
                            a_q[k] <= bus.in_a[k];
                            b_q[k] <= bus.in_b[k];
                        end
                        grp_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_MUL1;
                    end
                end
                S_MUL1: begin
                    for (int l = 0; l < LANES; l++) begin
                        m00_q[l] <= fqmul(a_q[{pair_w[l], 1'b0}], b_q[{pair_w[l], 1'b0}]);
                        m11_q[l] <= fqmul(a_q[{pair_w[l], 1'b1}], b_q[{pair_w[l], 1'b1}]);
                        m01_q[l] <= fqmul(a_q[{pair_w[l], 1'b0}], b_q[{pair_w[l], 1'b1}]);
                        m10_q[l] <= fqmul(a_q[{pair_w[l], 1'b1}], b_q[{pair_w[l], 1'b0}]);
                    end
                    state_q <= S_MUL2;
                end
                S_MUL2: begin
                    for (int l = 0; l < LANES; l++) begin
                        m11z_q[l] <= fqmul(m11_q[l], zeta_w[l]);
                    end
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    // Sums wrap at 16 bits; downstream stages do the final reduction.
                    for (int l = 0; l < LANES; l++) begin
                        res_q[{pair_w[l], 1'b0}] <= m11z_q[l] + m00_q[l];
                        res_q[{pair_w[l], 1'b1}] <= m01_q[l] + m10_q[l];
                    end
                    if (grp_q == 7'(G - 1)) begin
                        state_q <= S_FINISH;
                    end else begin
                        grp_q   <= grp_q + 7'd1;
                        state_q <= S_MUL1;
                    end
                end
                S_FINISH: begin
                    for (int k = 0; k < 256; k++) begin
                        out_q[k] <= res_q[k];
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out   = out_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_poly_basemul.sv
// Directed-sequence bench for poly_basemul with randomized operand
// polynomials checked against an arithmetic reference of the basemul rules.
module tb_poly_basemul;

    localparam int QM = 3329;

    logic clk = 1'b0;
    logic reset;

    poly_basemul_if bus ();

    poly_basemul #(.LANES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock.
    always #5 clk = ~clk;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [15:0] exp_q[$];
    int          ma [256];
    int          mb [256];

    // ---------------- reference model ----------------
    function automatic int fq(input int x, input int y);
        longint             p;
        logic signed [15:0] t;
        longint             r;
        p = longint'(x) * longint'(y);
        t = 16'(p * -3327);
        r = (p - longint'(t) * QM) / 65536;
        return int'(r);
    endfunction

    // Twiddle j = 17^bitrev7(64+j) in Montgomery form, smallest non-negative residue.
    function automatic int zeta_tab(input int j);
        int     k;
        int     br;
        longint v;
        k  = 64 + j;
        br = 0;
        for (int b = 0; b < 7; b++) if (((k >> b) & 1) != 0) br |= 1 << (6 - b);
        v = 1;
        for (int e = 0; e < br; e++) v = (v * 17) % QM;
        return int'((v * 65536) % QM);
    endfunction

    function automatic int wrap16(input int v);
        logic signed [15:0] s;
        s = 16'(v);
        return int'(s);
    endfunction

    task automatic build_expected();
        int z;
        int r0;
        int r1;
        for (int i = 0; i < 128; i++) begin
            z  = (i % 2 == 1) ? -zeta_tab(i / 2) : zeta_tab(i / 2);
            r0 = wrap16(fq(fq(ma[2*i+1], mb[2*i+1]), z) + fq(ma[2*i], mb[2*i]));
            r1 = wrap16(fq(ma[2*i], mb[2*i+1]) + fq(ma[2*i+1], mb[2*i]));
            exp_q.push_back(16'(r0));
            exp_q.push_back(16'(r1));
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        logic [15:0] e;
        for (int k = 0; k < 256; k++) begin
            e = exp_q.pop_front();
            check($sformatf("%s out[%0d]", tag, k), int'(bus.out[k]), int'($signed(e)));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic clear_model();
        for (int k = 0; k < 256; k++) begin
            ma[k] = 0;
            mb[k] = 0;
        end
    endtask

    task automatic random_model();
        for (int k = 0; k < 256; k++) begin
            ma[k] = int'($urandom_range(0, 2 * QM - 2)) - (QM - 1);
            mb[k] = int'($urandom_range(0, 2 * QM - 2)) - (QM - 1);
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < 256; k++) begin
            bus.in_a[k] = 16'(ma[k]);
            bus.in_b[k] = 16'(mb[k]);
        end
    endtask

    // Drives the operands, builds expectations, pulses start; returns just after the accept edge.
    task automatic start_op(input bit hold);
        drive_inputs();
        build_expected();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = hold;
    endtask

    // Called just after the accept edge: follows the operation to done and checks it.
    task automatic wait_op(input string tag, input int pa, input int pb, input bit hold);
        int edges;
        int busy_hi;
        busy_hi = (bus.busy === 1'b1) ? 1 : 0;
        edges   = 0;
        for (int k = 0; k < 256; k++) begin
            bus.in_a[k] = 16'($urandom);
            bus.in_b[k] = 16'($urandom);
        end
        while (bus.done !== 1'b1 && edges < 200) begin
            @(negedge clk);
            bus.start = hold || (edges == pa) || (edges == pb);
            @(posedge clk);
            #1;
            edges++;
            if (bus.busy === 1'b1) busy_hi++;
        end
        check({tag, " latency"}, edges, 97);
        check({tag, " busy cycles"}, busy_hi, 97);
        check({tag, " busy at done"}, int'(bus.busy), 0);
        check_outputs(tag);
    endtask

    task automatic run_op(input string tag, input int pa, input int pb);
        start_op(1'b0);
        wait_op(tag, pa, pb, 1'b0);
        @(posedge clk);
        #1;
        check({tag, " done single pulse"}, int'(bus.done), 0);
    endtask

    task automatic count_dones(input string tag, input int n);
        int dn;
        dn = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dn++;
        end
        check({tag, " spurious done"}, dn, 0);
    endtask

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    // ---------------- sequence ----------------
    initial begin
        int nz;
        reset     = 1'b1;
        bus.start = 1'b0;
        clear_model();
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset state", int'(bus.state), 0);
        check("reset out[0]", int'(bus.out[0]), 0);
        check("reset out[255]", int'(bus.out[255]), 0);
        @(negedge clk);
        reset = 1'b0;

        // All-zero operands.
        clear_model();
        run_op("zero", -1, -1);

        // Montgomery constant times 5 lands back on 5.
        clear_model();
        ma[0] = 2285;
        mb[0] = 5;
        run_op("a0b0", -1, -1);
        check("a0b0 spec out[0]", int'(bus.out[0]), 5);

        // Odd coefficients only, pair 0 uses +zeta.
        clear_model();
        ma[1] = 2285;
        mb[1] = 2285;
        run_op("a1b1", -1, -1);
        check("a1b1 spec out[0]", int'(bus.out[0]), -1103);
        check("a1b1 spec out[1]", int'(bus.out[1]), 0);

        // Pair 1 uses -zeta.
        clear_model();
        ma[3] = 2285;
        mb[3] = 2285;
        run_op("a3b3", -1, -1);
        check("a3b3 spec out[2]", int'(bus.out[2]), 1103);
        check("a3b3 spec out[0]", int'(bus.out[0]), 0);

        // Random operands.
        random_model();
        run_op("rand1", -1, -1);
        random_model();
        run_op("rand2", -1, -1);

        // start re-pulsed while busy is ignored; then a second operation.
        random_model();
        run_op("repulse", 9, 49);
        count_dones("repulse idle", 110);
        random_model();
        run_op("after repulse", -1, -1);

        // start held high is re-accepted on the idle cycle after done.
        random_model();
        start_op(1'b1);
        wait_op("hold first", -1, -1, 1'b1);
        random_model();
        @(negedge clk);
        drive_inputs();
        build_expected();
        @(posedge clk);
        #1;
        check("hold reaccept busy", int'(bus.busy), 1);
        check("hold reaccept done", int'(bus.done), 0);
        wait_op("hold second", -1, -1, 1'b0);

        // Reset in the middle of an operation.
        repeat (3) @(posedge clk);
        random_model();
        start_op(1'b0);
        repeat (39) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset busy", int'(bus.busy), 0);
        check("midreset done", int'(bus.done), 0);
        check("midreset state", int'(bus.state), 0);
        nz = 0;
        for (int k = 0; k < 256; k++) if (bus.out[k] !== 16'sd0) nz++;
        check("midreset out nonzero count", nz, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        count_dones("midreset", 120);
        random_model();
        run_op("post reset", -1, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
